// File: rtl/eight_bit_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : eight_bit_serial_subtractor_if
// Brief    : start/busy/done handshake and operand/result bus between the
//            operation sequencer (master) and the serial subtractor (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface eight_bit_serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             underflow;

    // Sequencer side: issues operations, observes results
    modport master (
        output start, a, b,
        input  busy, done, diff, underflow
    );

    // Subtractor side
    modport slave (
        input  start, a, b,
        output busy, done, diff, underflow
    );
endinterface : eight_bit_serial_subtractor_if
`default_nettype wire

// File: rtl/eight_bit_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : eight_bit_serial_subtractor
// Brief    : Bit-serial A - B, LSB first, one full-subtractor step per clock.
//            Optionally clamps the result to zero on borrow-out (underflow).
// Revision : 1.0 - initial release
// ============================================================================
module eight_bit_serial_subtractor #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    eight_bit_serial_subtractor_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_r_sh;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_underflow;

    logic             w_busy;
    logic             w_done;
    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_borrow_nxt;
    logic [WIDTH-1:0] w_r_sh_nxt;

    // Full-subtractor cell on the operand LSBs; new difference bit enters at the MSB
    assign w_d          = r_a_sh[0] ^ r_b_sh[0] ^ r_borrow;
    assign w_borrow_nxt = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_borrow);
    assign w_r_sh_nxt   = {w_d, r_r_sh[WIDTH-1:1]};
    assign w_last       = (r_cnt == c_LAST);
    // start is honoured in IDLE and in the DONE cycle (back-to-back), never while shifting
    assign w_accept     = bus.start && (r_state != S_SHIFT);

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.diff      = r_diff;
    assign bus.underflow = r_underflow;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = bus.start ? S_SHIFT : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand latch, serial step and result capture on the final step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_r_sh      <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_underflow <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_r_sh   <= w_r_sh_nxt;
            r_borrow <= w_borrow_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_underflow <= w_borrow_nxt;
                r_diff      <= (SATURATE && w_borrow_nxt) ? '0 : w_r_sh_nxt;
            end
        end
    end

endmodule : eight_bit_serial_subtractor
`default_nettype wire

// File: tb/tb_eight_bit_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_eight_bit_serial_subtractor
// Brief    : Directed bench; a saturating and a wrapping instance share the
//            same stimulus, expected results are queued on issue and popped
//            on each done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eight_bit_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             u;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t q_sat[$];
    exp_t q_raw[$];

    eight_bit_serial_subtractor_if #(.WIDTH(WIDTH)) bus_sat ();
    eight_bit_serial_subtractor_if #(.WIDTH(WIDTH)) bus_raw ();

    assign bus_raw.start = bus_sat.start;
    assign bus_raw.a     = bus_sat.a;
    assign bus_raw.b     = bus_sat.b;

    eight_bit_serial_subtractor #(.WIDTH(WIDTH), .SATURATE(1'b1)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_sat)
    );

    eight_bit_serial_subtractor #(.WIDTH(WIDTH), .SATURATE(1'b0)) u_dut_raw (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_raw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse from a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit push);
        exp_t e;
        bus_sat.a     = a;
        bus_sat.b     = b;
        bus_sat.start = 1'b1;
        if (push) begin
            e.u = (a < b);
            e.d = a - b;
            q_raw.push_back(e);
            e.d = e.u ? 8'h00 : e.d;
            q_sat.push_back(e);
        end
        @(negedge clk);
        bus_sat.start = 1'b0;
    endtask

    // Wait (bounded) for done; lat counts cycles since the accepting edge
    task automatic wait_done(input string tag, input int lat0, output int lat, output int busy_cnt);
        exp_t       e;
        logic [7:0] held;
        bit         moved;
        held     = bus_sat.diff;
        moved    = 1'b0;
        lat      = lat0;
        busy_cnt = int'(bus_sat.busy);
        while (!bus_sat.done && lat < 20) begin
            @(negedge clk);
            lat++;
            busy_cnt += int'(bus_sat.busy);
            if (!bus_sat.done && bus_sat.diff !== held) moved = 1'b1;
        end
        chk({tag, "_hold"}, 32'(moved), 32'd0);
        chk({tag, "_done_seen"}, 32'(bus_sat.done), 32'd1);
        chk({tag, "_raw_done"}, 32'(bus_raw.done), 32'(bus_sat.done));
        if (bus_sat.done) begin
            if (q_sat.size() == 0 || q_raw.size() == 0) begin
                chk({tag, "_queue"}, 32'd0, 32'd1);
            end else begin
                e = q_sat.pop_front();
                chk({tag, "_sat_diff"}, 32'(bus_sat.diff), 32'(e.d));
                chk({tag, "_sat_uf"}, 32'(bus_sat.underflow), 32'(e.u));
                e = q_raw.pop_front();
                chk({tag, "_raw_diff"}, 32'(bus_raw.diff), 32'(e.d));
                chk({tag, "_raw_uf"}, 32'(bus_raw.underflow), 32'(e.u));
            end
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'({bus_sat.busy, bus_raw.busy}), 32'd0);
        chk({tag, "_done"}, 32'({bus_sat.done, bus_raw.done}), 32'd0);
        chk({tag, "_diff"}, 32'({bus_sat.diff, bus_raw.diff}), 32'd0);
        chk({tag, "_uf"}, 32'({bus_sat.underflow, bus_raw.underflow}), 32'd0);
    endtask

    // Directed sequence
    initial begin
        int lat;
        int bc;
        int seen;
        bus_sat.start = 1'b0;
        bus_sat.a     = '0;
        bus_sat.b     = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operation, latency and busy width
        issue(8'd100, 8'd37, 1'b1);
        wait_done("op_100_37", 1, lat, bc);
        chk("op_100_37_latency", 32'(lat), 32'd9);
        chk("op_100_37_busy_cycles", 32'(bc), 32'd8);
        @(negedge clk);
        chk("done_one_cycle", 32'(bus_sat.done), 32'd0);

        // Underflow: clamped versus raw two's complement
        issue(8'd37, 8'd100, 1'b1);
        wait_done("op_37_100", 1, lat, bc);
        @(negedge clk);

        // Boundaries
        issue(8'd255, 8'd1, 1'b1);
        wait_done("op_255_1", 1, lat, bc);
        @(negedge clk);
        issue(8'd0, 8'd0, 1'b1);
        wait_done("op_0_0", 1, lat, bc);
        @(negedge clk);
        issue(8'd0, 8'd255, 1'b1);
        wait_done("op_0_255", 1, lat, bc);
        @(negedge clk);

        // start while busy is ignored, pins may change after acceptance
        issue(8'd50, 8'd20, 1'b1);
        @(negedge clk);
        bus_sat.start = 1'b1;
        bus_sat.a     = 8'd9;
        bus_sat.b     = 8'd9;
        @(negedge clk);
        bus_sat.start = 1'b0;
        bus_sat.a     = 8'hA5;
        bus_sat.b     = 8'hFE;
        wait_done("op_50_20", 3, lat, bc);
        chk("op_50_20_latency", 32'(lat), 32'd9);

        // Back-to-back: start raised in the done cycle; diff must hold 30 meanwhile
        issue(8'd200, 8'd73, 1'b1);
        wait_done("op_200_73", 1, lat, bc);
        chk("op_200_73_latency", 32'(lat), 32'd9);
        @(negedge clk);

        // Asynchronous reset mid-shift discards the operation
        issue(8'd120, 8'd3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_idle_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            seen += int'(bus_sat.done | bus_raw.done | bus_sat.busy);
        end
        chk("no_activity_after_reset", 32'(seen), 32'd0);
        issue(8'd200, 8'd150, 1'b1);
        wait_done("op_after_reset", 1, lat, bc);
        chk("op_after_reset_latency", 32'(lat), 32'd9);
        chk("queues_drained", 32'(q_sat.size() + q_raw.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_eight_bit_serial_subtractor
`default_nettype wire
